sram_mem_responder: RTL and testbench
=====================================

// Module: sram_mem_responder
// PURPOSE
//  Responder side of the MEM-stage data-memory interface. Accepts one 32-bit
//  read or write from the MEM stage and performs it as two 16-bit accesses on an
//  external asynchronous SRAM, using a programmable number of wait cycles.
//  Deasserts ready while an access is in flight. The top level ORs ~ready into
//  freez, so the whole pipeline stalls until the word transfer completes.
// PARAMETERS
//  SRAM_WAIT  5     cycles per 16-bit half access (legal range 2..15)
//  BASE_ADDR  1024  byte address mapped to SRAM halfword 0
// PORTS
//  clk          in   1   system clock; all state changes on the rising edge
//  rst          in   1   asynchronous, active-low reset
//  rd_en        in   1   MEM-stage read request; held stable while ready=0
//  wr_en        in   1   MEM-stage write request; held stable while ready=0
//  address      in   32  byte address (word aligned, >= BASE_ADDR)
//  wdata        in   32  write data
//  rdata        out  32  read data (registered); valid when ready=1 ending a read
//  ready        out  1   1 = no request pending, or current request completes now
//  sram_addr    out  18  SRAM halfword address
//  sram_dq_out  out  16  SRAM write data
//  sram_dq_oe   out  1   1 = drive sram_dq_out onto the SRAM DQ bus
//  sram_dq_in   in   16  SRAM read data
//  sram_we_n    out  1   SRAM write enable, active low
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, rdata=0, sram_addr=0,
//    sram_dq_out=0, sram_dq_oe=0, sram_we_n=1. An access in progress is
//    abandoned, with no partial-completion report. After reset release the
//    held request restarts from IDLE.
//  - Address: eff = address - BASE_ADDR. Low half = {eff[18:2],1'b0};
//    high half = {eff[18:2],1'b1}. Bits eff[1:0] and eff[31:19] are ignored.
//  - Request: req = rd_en | wr_en. If both are set, write has priority.
//  - ready = (state==IDLE & ~req) | (state==DONE). Combinational from state and
//    inputs.
//  - FSM states: IDLE -> LOW -> HIGH -> DONE -> IDLE.
//    IDLE: if req, latch is_wr, go to LOW with cnt=0.
//    LOW:  sram_addr=low half. Stay SRAM_WAIT cycles (cnt 0..SRAM_WAIT-1),
//          then go to HIGH with cnt=0.
//    HIGH: same as LOW, using the high half.
//    DONE: one cycle with ready=1, then IDLE. The pipeline advances here.
//  - Latency: request at cycle 0 (IDLE), ready=1 at cycle 2*SRAM_WAIT+1.
//    That is 2*SRAM_WAIT+2 cycles including the issue cycle. Back-to-back
//    requests add exactly one IDLE cycle between accesses.
//  - Write phases:
//    sram_dq_oe=1 for the whole phase.
//    sram_dq_out = wdata[15:0] in LOW, wdata[31:16] in HIGH.
//    sram_we_n=0 for cnt 0..SRAM_WAIT-2 and 1 on the last cycle of the phase
//    (address and data hold past the WE rising edge).
//  - Read phases:
//    sram_dq_oe=0 and sram_we_n=1.
//    rdata[15:0] <= sram_dq_in on the last LOW cycle.
//    rdata[31:16] <= sram_dq_in on the last HIGH cycle.
//    rdata holds its value otherwise; writes do not change it.
//  - Outside LOW/HIGH: sram_we_n=1, sram_dq_oe=0, and sram_addr holds its
//    last value.
//  - A request dropped mid-access (protocol violation) is ignored. The
//    access still runs to DONE.
//  - cnt is 4 bits wide.
// TESTING
//  - Reset: rst=0 during a write LOW phase -> sram_we_n=1, sram_dq_oe=0 and
//    state=IDLE immediately (async); ready=1 with rd_en=wr_en=0.
//  - Write: address=1032, wdata=32'hCAFE_BEEF, SRAM_WAIT=5 -> sram_addr=4 with
//    DQ=BEEF, then sram_addr=5 with DQ=CAFE. we_n low for 4 cycles per half.
//    ready=1 exactly 11 cycles after the request.
//  - Read: read back address 1032 from the SRAM model -> rdata=32'hCAFE_BEEF
//    at ready. ready=0 for cycles 0..10 of the access.
//  - Back-to-back: write 1024 <- 1, then read 1024 with no idle gap ->
//    second ready 12 cycles after the first; rdata=1.
//  - Both rd_en and wr_en=1 -> a write is performed and rdata is unchanged.
//    Address 1024+2^19 aliases to sram_addr 0/1.
//  - SRAM_WAIT=2: write, then read 1028 -> total latency 6 cycles each;
//    we_n low for exactly 1 cycle per half.

Source files
------------

// File: rtl/sram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mem_responder
//  Description : MEM-stage data-memory responder. Performs each 32-bit read
//                or write as two 16-bit accesses on an external asynchronous
//                SRAM, each half lasting SRAM_WAIT cycles. ready is low while
//                an access is in flight so the pipeline stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_responder #(
    parameter int          SRAM_WAIT = 5,      // cycles per half access, 2..15
    parameter logic [31:0] BASE_ADDR = 32'd1024 // byte address of halfword 0
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    // Last counter value of a phase, and last counter value with WE low.
    localparam logic [3:0] c_LAST   = 4'(SRAM_WAIT - 1);
    localparam logic [3:0] c_WE_END = 4'(SRAM_WAIT - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_wr;
    logic [31:0] r_rdata;
    logic [17:0] r_sram_addr;
    logic [15:0] r_dq_out;
    logic        r_dq_oe;
    logic        r_we_n;

    logic        w_req;
    logic        w_ready;
    logic [31:0] w_eff;
    logic [17:0] w_addr_lo;
    logic [17:0] w_addr_hi;
    logic        w_unused_bits;

    // Request decode and halfword address generation. Byte offset and the
    // bits above the SRAM window are ignored, so higher addresses alias.
    assign w_req         = rd_en | wr_en;
    assign w_eff         = address - BASE_ADDR;
    assign w_addr_lo     = {w_eff[18:2], 1'b0};
    assign w_addr_hi     = {w_eff[18:2], 1'b1};
    assign w_unused_bits = ^{w_eff[31:19], w_eff[1:0]};

    // ready is high when idle with nothing asked, or on the completion cycle.
    assign w_ready = ((r_state == ST_IDLE) && !w_req) || (r_state == ST_DONE);

    assign ready       = w_ready;
    assign rdata       = r_rdata;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

    // Access sequencer: outputs are registered one cycle ahead, so the value
    // loaded on a transition is the value seen during the next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_is_wr     <= 1'b0;
            r_rdata     <= 32'd0;
            r_sram_addr <= 18'd0;
            r_dq_out    <= 16'd0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // Write wins when both enables are set.
                        r_is_wr     <= wr_en;
                        r_cnt       <= 4'd0;
                        r_state     <= ST_LOW;
                        r_sram_addr <= w_addr_lo;
                        r_dq_oe     <= wr_en;
                        r_we_n      <= ~wr_en;
                        if (wr_en) begin
                            r_dq_out <= wdata[15:0];
                        end
                    end
                end

                ST_LOW: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt       <= 4'd0;
                        r_state     <= ST_HIGH;
                        r_sram_addr <= w_addr_hi;
                        r_dq_oe     <= r_is_wr;
                        r_we_n      <= ~r_is_wr;
                        if (r_is_wr) begin
                            r_dq_out <= wdata[31:16];
                        end else begin
                            r_rdata[15:0] <= sram_dq_in;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        // WE rises for the final cycle so address/data hold past it.
                        r_we_n <= ~r_is_wr | (r_cnt == c_WE_END);
                    end
                end

                ST_HIGH: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_DONE;
                        r_dq_oe <= 1'b0;
                        r_we_n  <= 1'b1;
                        if (!r_is_wr) begin
                            r_rdata[31:16] <= sram_dq_in;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_we_n <= ~r_is_wr | (r_cnt == c_WE_END);
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_mem_responder
//  Description : Directed self-checking bench for sram_mem_responder, with a
//                SRAM_WAIT=5 instance and a SRAM_WAIT=2 instance, each backed
//                by a simple asynchronous SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;      // 0 = SRAM_WAIT 5 instance, 1 = SRAM_WAIT 2 instance
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;

    logic        rd1, wr1, rd2, wr2;
    logic [31:0] rdata1, rdata2;
    logic        ready1, ready2;
    logic [17:0] addr1, addr2;
    logic [15:0] dq_out1, dq_out2, dq_in1, dq_in2;
    logic        oe1, oe2, we_n1, we_n2;

    logic [31:0] m_rdata;
    logic        m_ready;
    logic [17:0] m_addr;
    logic [15:0] m_dq_out;
    logic        m_oe;
    logic        m_we_n;

    logic [15:0] mem1 [0:1023];
    logic [15:0] mem2 [0:1023];

    int total = 0;
    int bad   = 0;

    assign rd1 = rd_en & ~sel;
    assign wr1 = wr_en & ~sel;
    assign rd2 = rd_en & sel;
    assign wr2 = wr_en & sel;

    assign m_rdata  = sel ? rdata2  : rdata1;
    assign m_ready  = sel ? ready2  : ready1;
    assign m_addr   = sel ? addr2   : addr1;
    assign m_dq_out = sel ? dq_out2 : dq_out1;
    assign m_oe     = sel ? oe2     : oe1;
    assign m_we_n   = sel ? we_n2   : we_n1;

    sram_mem_responder #(.SRAM_WAIT(5), .BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(address),
        .wdata(wdata), .rdata(rdata1), .ready(ready1), .sram_addr(addr1),
        .sram_dq_out(dq_out1), .sram_dq_oe(oe1), .sram_dq_in(dq_in1),
        .sram_we_n(we_n1)
    );

    sram_mem_responder #(.SRAM_WAIT(2), .BASE_ADDR(32'd1024)) dut2 (
        .clk(clk), .rst(rst), .rd_en(rd2), .wr_en(wr2), .address(address),
        .wdata(wdata), .rdata(rdata2), .ready(ready2), .sram_addr(addr2),
        .sram_dq_out(dq_out2), .sram_dq_oe(oe2), .sram_dq_in(dq_in2),
        .sram_we_n(we_n2)
    );

    // SRAM models: combinational read, write while WE is low.
    assign dq_in1 = mem1[addr1[9:0]];
    assign dq_in2 = mem2[addr2[9:0]];
    always @(posedge clk) if (!we_n1) mem1[addr1[9:0]] <= dq_out1;
    always @(posedge clk) if (!we_n2) mem2[addr2[9:0]] <= dq_out2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        rd_en = 1'b0;
        wr_en = 1'b0;
        tick();
    endtask

    // Issue one request and follow it to ready, tallying WE-low cycles.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [17:0] exp_lo, input logic [17:0] exp_hi,
                              input logic [15:0] d_lo, input logic [15:0] d_hi,
                              output int cyc, output logic rdy0,
                              output int n_lo, output int n_hi, output int n_bad);
        rd_en   = rd;
        wr_en   = wr;
        address = addr;
        wdata   = data;
        #1;
        rdy0  = m_ready;
        cyc   = 0;
        n_lo  = 0;
        n_hi  = 0;
        n_bad = 0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (!m_we_n) begin
                if (m_oe && m_addr == exp_lo && m_dq_out == d_lo) n_lo++;
                else if (m_oe && m_addr == exp_hi && m_dq_out == d_hi) n_hi++;
                else n_bad++;
            end
            if (m_ready) break;
        end
    endtask

    task automatic test_reset;
        sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; wdata = 32'd0;
        rst = 1'b0;
        tick(); tick();
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", m_ready); end
        total++; if (m_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h expected 0", m_rdata); end
        total++; if (m_we_n !== 1'b1 || m_oe !== 1'b0) begin bad++; $display("FAIL reset_we_oe: got we_n=%b oe=%b expected 1/0", m_we_n, m_oe); end
        total++; if (m_addr !== 18'd0) begin bad++; $display("FAIL reset_addr: got %h expected 0", m_addr); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write;
        int cyc, nl, nh, nb; logic r0;
        run_access(1'b0, 1'b1, 32'd1032, 32'hCAFE_BEEF, 18'd4, 18'd5, 16'hBEEF, 16'hCAFE, cyc, r0, nl, nh, nb);
        total++; if (r0 !== 1'b0) begin bad++; $display("FAIL write_ready_c0: got %b expected 0", r0); end
        total++; if (cyc != 11) begin bad++; $display("FAIL write_latency: got %0d expected 11", cyc); end
        total++; if (nl != 4 || nh != 4 || nb != 0) begin bad++; $display("FAIL write_we_pattern: got lo=%0d hi=%0d other=%0d expected 4/4/0", nl, nh, nb); end
        total++; if (mem1[4] !== 16'hBEEF || mem1[5] !== 16'hCAFE) begin bad++; $display("FAIL write_mem: got %h/%h expected beef/cafe", mem1[4], mem1[5]); end
        go_idle();
    endtask

    task automatic test_read;
        int cyc, nl, nh, nb; logic r0;
        run_access(1'b1, 1'b0, 32'd1032, 32'd0, 18'd4, 18'd5, 16'd0, 16'd0, cyc, r0, nl, nh, nb);
        total++; if (r0 !== 1'b0) begin bad++; $display("FAIL read_ready_c0: got %b expected 0", r0); end
        total++; if (cyc != 11) begin bad++; $display("FAIL read_latency: got %0d expected 11", cyc); end
        total++; if (m_rdata !== 32'hCAFE_BEEF) begin bad++; $display("FAIL read_data: got %h expected cafebeef", m_rdata); end
        total++; if (nl + nh + nb != 0) begin bad++; $display("FAIL read_we: got %0d we_n-low cycles expected 0", nl + nh + nb); end
        go_idle();
    endtask

    task automatic test_reset_mid_write;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd2048; wdata = 32'h1111_2222;
        tick(); tick();
        total++; if (m_we_n !== 1'b0) begin bad++; $display("FAIL midrst_pre_we: got %b expected 0", m_we_n); end
        #2 rst = 1'b0;
        #1;
        total++; if (m_we_n !== 1'b1 || m_oe !== 1'b0) begin bad++; $display("FAIL midrst_we_oe: got we_n=%b oe=%b expected 1/0", m_we_n, m_oe); end
        total++; if (m_addr !== 18'd0 || m_rdata !== 32'd0) begin bad++; $display("FAIL midrst_regs: got addr=%h rdata=%h expected 0/0", m_addr, m_rdata); end
        rd_en = 1'b0; wr_en = 1'b0;
        #1;
        total++; if (m_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b expected 1", m_ready); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        int cyc, nl, nh, nb; logic r0;
        run_access(1'b0, 1'b1, 32'd1024, 32'd1, 18'd0, 18'd1, 16'h0001, 16'h0000, cyc, r0, nl, nh, nb);
        total++; if (cyc != 11 || nl != 4 || nh != 4 || nb != 0) begin bad++; $display("FAIL b2b_write: got cyc=%0d lo=%0d hi=%0d other=%0d expected 11/4/4/0", cyc, nl, nh, nb); end
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 18'd1, 16'd0, 16'd0, cyc, r0, nl, nh, nb);
        total++; if (cyc != 12) begin bad++; $display("FAIL b2b_gap: got %0d expected 12", cyc); end
        total++; if (m_rdata !== 32'd1) begin bad++; $display("FAIL b2b_rdata: got %h expected 1", m_rdata); end
        go_idle();
    endtask

    task automatic test_both_alias;
        int cyc, nl, nh, nb; logic r0;
        run_access(1'b1, 1'b1, 32'd525312, 32'h1234_5678, 18'd0, 18'd1, 16'h5678, 16'h1234, cyc, r0, nl, nh, nb);
        total++; if (cyc != 11 || nl != 4 || nh != 4 || nb != 0) begin bad++; $display("FAIL both_write: got cyc=%0d lo=%0d hi=%0d other=%0d expected 11/4/4/0", cyc, nl, nh, nb); end
        total++; if (m_rdata !== 32'd1) begin bad++; $display("FAIL both_rdata_hold: got %h expected 1", m_rdata); end
        go_idle();
        run_access(1'b1, 1'b0, 32'd1024, 32'd0, 18'd0, 18'd1, 16'd0, 16'd0, cyc, r0, nl, nh, nb);
        total++; if (m_rdata !== 32'h1234_5678) begin bad++; $display("FAIL alias_read: got %h expected 12345678", m_rdata); end
        go_idle();
    endtask

    task automatic test_wait2;
        int cyc, nl, nh, nb; logic r0;
        sel = 1'b1;
        tick();
        run_access(1'b0, 1'b1, 32'd1028, 32'hA5A5_5A5A, 18'd2, 18'd3, 16'h5A5A, 16'hA5A5, cyc, r0, nl, nh, nb);
        total++; if (cyc != 5 || r0 !== 1'b0) begin bad++; $display("FAIL w2_write_latency: got cyc=%0d ready0=%b expected 5/0", cyc, r0); end
        total++; if (nl != 1 || nh != 1 || nb != 0) begin bad++; $display("FAIL w2_we_pattern: got lo=%0d hi=%0d other=%0d expected 1/1/0", nl, nh, nb); end
        go_idle();
        run_access(1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 18'd3, 16'd0, 16'd0, cyc, r0, nl, nh, nb);
        total++; if (cyc != 5) begin bad++; $display("FAIL w2_read_latency: got %0d expected 5", cyc); end
        total++; if (m_rdata !== 32'hA5A5_5A5A) begin bad++; $display("FAIL w2_read_data: got %h expected a5a55a5a", m_rdata); end
        go_idle();
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_reset_mid_write();
        test_back_to_back();
        test_both_alias();
        test_wait2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
